// File: rtl/clk_div_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_gen_pkg
// Shared constants and types for the clock divider / clock-enable generator.
//   DIV_W          : default width of a divide value
//   DEFAULT_DIV    : divide value every channel holds after reset
//   STARTUP_CYCLES : default oscillator settling hold after reset release
//   div_t          : divide-value type at the default width
//   idx_width()    : channel-select width, never less than one bit
// -----------------------------------------------------------------------------
package clk_div_gen_pkg;

    localparam int unsigned DIV_W          = 8;
    localparam int unsigned DEFAULT_DIV    = 16;
    localparam int unsigned STARTUP_CYCLES = 16;

    typedef logic [DIV_W-1:0] div_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// -----------------------------------------------------------------------------
// clk_div_gen_if
// Control/status bundle of clk_div_gen.
//   en         : global run (master -> slave)
//   cfg_valid  : divider update request (master -> slave)
//   cfg_ch     : target channel (master -> slave)
//   cfg_div    : new divide value, 0 = channel off (master -> slave)
//   cfg_ready  : update accepted when cfg_valid && cfg_ready (slave -> master)
//   locked     : startup hold complete (slave -> master)
//   ce         : per-channel one-cycle enable pulse (slave -> master)
//   clk_out    : per-channel divided clock (slave -> master)
// -----------------------------------------------------------------------------
interface clk_div_gen_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = clk_div_gen_pkg::DIV_W
);
    import clk_div_gen_pkg::*;

    localparam int unsigned CH_W = idx_width(NUM_CH);

    logic              en;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic              locked;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk_out;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, locked, ce, clk_out
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, locked, ce, clk_out
    );

endinterface

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: period counter, active divide value, one-deep pending
// update register with glitch-free apply, and registered ce / clk_out.
//   clk       : oscillator clock
//   rst_n     : asynchronous active-low reset
//   i_run     : locked && en
//   i_first   : first cycle of i_run after it was low
//   i_wr      : accepted update for this channel (only when pending is empty)
//   i_wr_div  : divide value carried by the update
//   o_pend    : pending update waiting to be applied
//   o_ce      : one-cycle pulse at terminal count
//   o_clk_out : high for the first ceil(N/2) counts of each period
// -----------------------------------------------------------------------------
module clk_div_chan #(
    parameter int unsigned DIV_W       = clk_div_gen_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = clk_div_gen_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_first,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_pend,
    output logic             o_ce,
    output logic             o_clk_out
);

    typedef logic [DIV_W-1:0] cnt_t;

    localparam cnt_t DIV_RST = cnt_t'(DEFAULT_DIV);

    cnt_t r_cnt;
    cnt_t r_div;
    cnt_t r_pend_div;
    logic r_pend_vld;
    logic r_ce;
    logic r_clk_out;

    logic w_term;
    logic w_apply;
    cnt_t w_div_d;
    cnt_t w_cnt_d;
    cnt_t w_half;
    logic w_ce_d;
    logic w_clk_out_d;

    always_comb begin
        w_term  = (r_div != '0) && (r_cnt == r_div - 1'b1);
        // A pending value only takes over at a period boundary, or when the
        // channel produces nothing anyway, so no runt pulse is ever emitted.
        w_apply = r_pend_vld && (w_term || (r_div == '0) || !i_run);
        w_div_d = w_apply ? r_pend_div : r_div;

        // i_first holds the counter at 0 for one cycle so the registered
        // outputs show a clean period start in the first running cycle.
        if (!i_run || i_first || w_apply || w_term || (r_div == '0)) begin
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end

        w_half      = (w_div_d >> 1) + cnt_t'(w_div_d[0]);
        w_ce_d      = i_run && (w_div_d != '0) && (w_cnt_d == w_div_d - 1'b1);
        w_clk_out_d = i_run && (w_div_d != '0) && (w_cnt_d < w_half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= DIV_RST;
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_ce       <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_d;
            r_div     <= w_div_d;
            r_ce      <= w_ce_d;
            r_clk_out <= w_clk_out_d;
            // i_wr is only raised while nothing is pending, so it never
            // coincides with an apply.
            if (i_wr) begin
                r_pend_div <= i_wr_div;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign o_pend    = r_pend_vld;
    assign o_ce      = r_ce;
    assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
// Multi-channel runtime-programmable clock-enable / divided-clock generator.
// Holds the startup (oscillator settling) counter, decodes configuration
// writes to channels and muxes cfg_ready; each channel is a clk_div_chan.
//   clk   : oscillator clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of clk_div_gen_if (en, cfg_*, locked, ce, clk_out)
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned DIV_W          = clk_div_gen_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV    = clk_div_gen_pkg::DEFAULT_DIV,
    parameter int unsigned STARTUP_CYCLES = clk_div_gen_pkg::STARTUP_CYCLES
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_gen_if.slave  bus
);
    import clk_div_gen_pkg::*;

    localparam int unsigned CH_W = idx_width(NUM_CH);
    localparam int unsigned SU_W = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);

    logic [SU_W-1:0]   r_su_cnt;
    logic              r_locked;
    logic              r_run;

    logic              w_run;
    logic              w_first;
    logic              w_ready;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_ce;
    logic [NUM_CH-1:0] w_clk_out;

    // locked rises in the cycle after STARTUP_CYCLES cycles since release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_su_cnt <= '0;
            r_locked <= 1'b0;
        end else if (!r_locked) begin
            if (r_su_cnt == SU_LAST) begin
                r_locked <= 1'b1;
            end else begin
                r_su_cnt <= r_su_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= w_run;
        end
    end

    assign w_run   = r_locked && bus.en;
    assign w_first = w_run && !r_run;

    // Unmapped channel numbers fall through with ready high, so such a
    // request is accepted and dropped.
    always_comb begin
        w_ready = 1'b1;
        w_wr    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_ch == CH_W'(i)) begin
                w_ready = !w_pend[i];
                w_wr[i] = bus.cfg_valid && !w_pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_run     (w_run),
            .i_first   (w_first),
            .i_wr      (w_wr[g]),
            .i_wr_div  (bus.cfg_div),
            .o_pend    (w_pend[g]),
            .o_ce      (w_ce[g]),
            .o_clk_out (w_clk_out[g])
        );
    end

    assign bus.cfg_ready = w_ready;
    assign bus.locked    = r_locked;
    assign bus.ce        = w_ce;
    assign bus.clk_out   = w_clk_out;

endmodule
